rst_sync_reset_sequencer: RTL and testbench
===========================================

Name: rst_sync_reset_sequencer

Overview:
- Drives the synchronous, active-high reset inputs of downstream register domains. Each domain uses the `if (sync_rst) ... else ...` style inside `always_ff @(posedge clk)`.
- Asserts all domain resets on power-up or on software request, holds them for a fixed time, then releases them one domain at a time with a fixed stagger.
- Reports busy, done, and a completed-sequence count.
- Sits between the top-level reset/control logic and the per-domain synchronous-reset consumers.

Parameters:
- NUM_DOMAINS, 4: number of downstream reset outputs; must be >= 1.
- HOLD_CYCLES, 16: cycles all outputs stay asserted before the first release; must be >= 1.
- STAGGER_CYCLES, 4: cycles between consecutive domain releases; must be >= 1.
- CNT_W, 8: width of the completed-sequence counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- sync_rst  input  1  block reset, synchronous, active-high.
- rst_req_i  input  1  level request for a new reset sequence; held high by the requester until ack.
- rst_req_ack_o  output  1  one-cycle pulse when the request is accepted.
- rst_out_o  output  NUM_DOMAINS  per-domain sync reset, active-high, registered.
- rst_busy_o  output  1  high whenever the state is not IDLE.
- rst_done_o  output  1  one-cycle pulse when a sequence completes.
- rst_count_o  output  CNT_W  completed sequences, saturating.

Behaviour:
- Interface: one clock (clk). Reset sync_rst is synchronous and active-high. Every output is a flop; there are no combinational paths from inputs to outputs.
- Values while sync_rst is sampled high:
  - state = ASSERT, hold_cnt = 0, stag_cnt = 0, idx = 0.
  - rst_out_o = all ones, rst_busy_o = 1.
  - rst_req_ack_o = 0, rst_done_o = 0, rst_count_o = 0.
  - So a power-on sequence starts automatically when sync_rst falls.
- States: IDLE, ASSERT, RELEASE, DONE.
- ASSERT:
  - rst_out_o is all ones.
  - Each edge: if hold_cnt == HOLD_CYCLES-1, go to RELEASE, clear rst_out_o[0], stag_cnt = 0, idx = 0. Otherwise hold_cnt++.
  - rst_req_i is ignored here (not acked) and stays pending.
- RELEASE:
  - Each edge: if stag_cnt == STAGGER_CYCLES-1, then idx++, clear rst_out_o[idx], stag_cnt = 0. Otherwise stag_cnt++.
  - Domain k therefore falls STAGGER_CYCLES*k cycles after domain 0.
  - On the edge after rst_out_o[NUM_DOMAINS-1] falls, go to DONE.
  - With NUM_DOMAINS = 1, DONE follows domain 0 directly on the next edge.
- DONE (one cycle):
  - rst_done_o = 1.
  - rst_count_o increments, saturating at all ones.
  - Unconditionally go to IDLE; a pending request is not taken in DONE.
- IDLE:
  - rst_out_o is all zeros; rst_busy_o = 0.
  - If rst_req_i = 1: go to ASSERT, set rst_out_o to all ones, hold_cnt = 0, rst_req_ack_o = 1 for one cycle.
- Timing from the last edge with sync_rst = 1 (edge n's results visible in cycle n; defaults):
  - rst_out_o[0] falls at cycle 16; [1] at 20; [2] at 24; [3] at 28.
  - rst_done_o = 1 in cycle 29; rst_busy_o = 0 from cycle 30.
  - Request-triggered sequences use the same timing, measured from the ack cycle instead of cycle 0.
- Released domains never re-assert except on:
  - sync_rst,
  - an accepted request, or
  - an abort (see Optional Feature).
- sync_rst mid-sequence: restarts in ASSERT with all outputs high and all counters cleared. rst_count_o is also cleared.

Optional Feature:
- Macro RST_SEQ_ABORT_EN.
- Defined:
  - rst_req_i = 1 in RELEASE aborts the sequence on that edge.
  - rst_out_o returns to all ones, hold_cnt = 0, idx = 0, stag_cnt = 0, state = ASSERT.
  - rst_req_ack_o pulses; rst_done_o does not pulse; rst_count_o is unchanged.
- Undefined: rst_req_i in RELEASE is ignored and stays pending until IDLE.

Test Plan:
- Power-on: sync_rst high 3 cycles then low, rst_req_i = 0 -> all outputs high through cycle 15; bit0 low at cycle 16, bit3 low at 28; done pulse at 29; count = 1; busy low from 30.
- Request in IDLE: after the power-on sequence, rst_req_i = 1 for one cycle -> ack pulse and rst_out_o = 4'hF the next cycle; same 16/4 release timing; count = 2.
- Request during ASSERT: rst_req_i held high from cycle 5 -> no ack until the first IDLE cycle (30); a second sequence follows; no early re-assert.
- Abort (RST_SEQ_ABORT_EN defined): rst_req_i = 1 at cycle 21 (bits 0 and 1 released) -> rst_out_o = 4'hF next cycle; ack pulses; no done; count unchanged; release restarts 16 cycles later. Same stimulus with the macro undefined -> sequence completes normally, then the request is accepted at cycle 30.
- Mid-sequence reset: sync_rst asserted at cycle 22 for 1 cycle -> rst_out_o = 4'hF, count = 0, full power-on timing re-runs.
- Saturation: CNT_W = 2, run 5 sequences -> rst_count_o sticks at 3.

Source files
------------

// File: rtl/rst_sync_reset_sequencer.sv
// Reset sequencer: holds all domain resets high, then releases them in order with a fixed stagger.
// Optional macro RST_SEQ_ABORT_EN lets a request during the release phase restart the sequence.
module rst_sync_reset_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4,
    parameter int CNT_W          = 8
) (
    input  logic                   clk,
    input  logic                   sync_rst,
    input  logic                   rst_req_i,
    output logic                   rst_req_ack_o,
    output logic [NUM_DOMAINS-1:0] rst_out_o,
    output logic                   rst_busy_o,
    output logic                   rst_done_o,
    output logic [CNT_W-1:0]       rst_count_o
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int STAG_W = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;
    localparam int IDX_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ASSERT,
        RELEASE,
        DONE
    } state_t;

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [STAG_W-1:0]   stag_cnt;
    logic [IDX_W-1:0]    idx;

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state         <= ASSERT;
            hold_cnt      <= '0;
            stag_cnt      <= '0;
            idx           <= '0;
            rst_out_o     <= '1;
            rst_busy_o    <= 1'b1;
            rst_req_ack_o <= 1'b0;
            rst_done_o    <= 1'b0;
            rst_count_o   <= '0;
        end else begin
            rst_req_ack_o <= 1'b0;
            rst_done_o    <= 1'b0;
            case (state)
                IDLE: begin
                    rst_out_o  <= '0;
                    rst_busy_o <= 1'b0;
                    if (rst_req_i) begin
                        state         <= ASSERT;
                        rst_out_o     <= '1;
                        rst_busy_o    <= 1'b1;
                        hold_cnt      <= '0;
                        rst_req_ack_o <= 1'b1;
                    end
                end
                ASSERT: begin
                    rst_out_o <= '1;
                    if (hold_cnt == HOLD_LAST) begin
                        state     <= RELEASE;
                        rst_out_o <= ~NUM_DOMAINS'(1);
                        stag_cnt  <= '0;
                        idx       <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RELEASE: begin
`ifdef RST_SEQ_ABORT_EN
                    if (rst_req_i) begin
                        state         <= ASSERT;
                        rst_out_o     <= '1;
                        hold_cnt      <= '0;
                        stag_cnt      <= '0;
                        idx           <= '0;
                        rst_req_ack_o <= 1'b1;
                    end else
`endif
                    if (idx == IDX_LAST) begin
                        state      <= DONE;
                        rst_done_o <= 1'b1;
                        if (rst_count_o != '1) begin
                            rst_count_o <= rst_count_o + 1'b1;
                        end
                    end else if (stag_cnt == STAG_LAST) begin
                        // Lower domains are already released, so shifting clears exactly the next one.
                        idx       <= idx + 1'b1;
                        rst_out_o <= rst_out_o << 1;
                        stag_cnt  <= '0;
                    end else begin
                        stag_cnt <= stag_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    rst_out_o  <= '0;
                    rst_busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rst_sync_reset_sequencer.sv
// Bench for rst_sync_reset_sequencer: phase-based reference model plus directed timing checks.
// Follows RST_SEQ_ABORT_EN the same way the design does.
module tb_rst_sync_reset_sequencer;

    localparam int ND    = 4;
    localparam int HOLD  = 16;
    localparam int STAG  = 4;
    localparam int LAST  = HOLD + STAG * (ND - 1);
`ifdef RST_SEQ_ABORT_EN
    localparam bit ABORT = 1'b1;
`else
    localparam bit ABORT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          sync_rst = 1'b1;
    logic          rst_req_i = 1'b0;
    logic          rst_req_ack_o;
    logic [ND-1:0] rst_out_o;
    logic          rst_busy_o;
    logic          rst_done_o;
    logic [7:0]    rst_count_o;
    logic          sat_ack;
    logic [ND-1:0] sat_out;
    logic          sat_busy;
    logic          sat_done;
    logic [1:0]    sat_count;

    int checks = 0;
    int fails  = 0;

    rst_sync_reset_sequencer #(
        .NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .CNT_W(8)
    ) dut (
        .clk(clk), .sync_rst(sync_rst), .rst_req_i(rst_req_i),
        .rst_req_ack_o(rst_req_ack_o), .rst_out_o(rst_out_o),
        .rst_busy_o(rst_busy_o), .rst_done_o(rst_done_o), .rst_count_o(rst_count_o)
    );

    rst_sync_reset_sequencer #(
        .NUM_DOMAINS(ND), .HOLD_CYCLES(HOLD), .STAGGER_CYCLES(STAG), .CNT_W(2)
    ) dut_sat (
        .clk(clk), .sync_rst(sync_rst), .rst_req_i(rst_req_i),
        .rst_req_ack_o(sat_ack), .rst_out_o(sat_out),
        .rst_busy_o(sat_busy), .rst_done_o(sat_done), .rst_count_o(sat_count)
    );

    always #5 clk = ~clk;

    // Model: a sequence is a phase counter ph since its start; every output is a function of ph.
    int cyc = 0;
    int ph = 0;
    int m_count = 0;
    bit m_active = 1'b0;
    bit m_ack = 1'b0;
    bit m_valid = 1'b0;

    always @(posedge clk) begin
        if (sync_rst) begin
            cyc      <= 0;
            ph       <= 0;
            m_active <= 1'b1;
            m_count  <= 0;
            m_ack    <= 1'b0;
            m_valid  <= 1'b1;
        end else begin
            cyc   <= cyc + 1;
            m_ack <= 1'b0;
            if (m_active) begin
                if (ABORT && rst_req_i && ph >= HOLD && ph <= LAST) begin
                    ph    <= 0;
                    m_ack <= 1'b1;
                end else if (ph == LAST + 1) begin
                    m_active <= 1'b0;
                end else begin
                    ph <= ph + 1;
                    if (ph == LAST) m_count <= m_count + 1;
                end
            end else if (rst_req_i) begin
                m_active <= 1'b1;
                ph       <= 0;
                m_ack    <= 1'b1;
            end
        end
    end

    function automatic logic [ND-1:0] exp_out();
        logic [ND-1:0] v;
        for (int k = 0; k < ND; k++) v[k] = m_active && (ph < HOLD + STAG * k);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("model rst_out", 32'(rst_out_o), 32'(exp_out()));
            check("model busy", 32'(rst_busy_o), 32'(m_active));
            check("model done", 32'(rst_done_o), 32'(m_active && ph == LAST + 1));
            check("model ack", 32'(rst_req_ack_o), 32'(m_ack));
            check("model count", 32'(rst_count_o), (m_count > 255) ? 32'd255 : 32'(m_count));
            check("model sat rst_out", 32'(sat_out), 32'(exp_out()));
            check("model sat count", 32'(sat_count), (m_count > 3) ? 32'd3 : 32'(m_count));
        end
    end

    task automatic wait_cyc(input int n);
        int i = 0;
        while (cyc != n && i < 400) begin
            @(negedge clk);
            i++;
        end
        if (cyc != n) check("wait_cyc timeout", 32'(cyc), 32'(n));
    endtask

    task automatic request(output int ack_cyc);
        ack_cyc = -1;
        rst_req_i = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rst_req_ack_o) begin
                ack_cyc = cyc;
                break;
            end
        end
        rst_req_i = 1'b0;
        if (ack_cyc < 0) check("ack timeout", 32'hFFFF_FFFF, 32'd0);
    endtask

    int a, a2, b, c, d, e;

    initial begin
        repeat (3) @(negedge clk);
        sync_rst = 1'b0;

        // Power-on sequence
        check("por out c0", 32'(rst_out_o), 32'hF);
        check("por busy c0", 32'(rst_busy_o), 32'd1);
        check("por count c0", 32'(rst_count_o), 32'd0);
        check("por done c0", 32'(rst_done_o), 32'd0);
        wait_cyc(15); check("por out c15", 32'(rst_out_o), 32'hF);
        wait_cyc(16); check("por out c16", 32'(rst_out_o), 32'hE);
        wait_cyc(20); check("por out c20", 32'(rst_out_o), 32'hC);
        wait_cyc(28); check("por out c28", 32'(rst_out_o), 32'h0);
        wait_cyc(29); check("por done c29", 32'(rst_done_o), 32'd1);
                      check("por count c29", 32'(rst_count_o), 32'd1);
        wait_cyc(30); check("por busy c30", 32'(rst_busy_o), 32'd0);

        // Request from IDLE
        wait_cyc(32);
        request(a);
        check("idle req ack cycle", 32'(a), 32'd33);
        check("idle req out", 32'(rst_out_o), 32'hF);
        wait_cyc(a + 16); check("idle req out +16", 32'(rst_out_o), 32'hE);
        wait_cyc(a + 29); check("idle req count", 32'(rst_count_o), 32'd2);
        wait_cyc(a + 30); check("idle req busy +30", 32'(rst_busy_o), 32'd0);

        // Request raised during ASSERT waits for IDLE
        wait_cyc(a + 32);
        request(a2);
        wait_cyc(a2 + 5);
        request(b);
        check("pending req ack cycle", 32'(b - a2), 32'd31);
        check("pending req count", 32'(rst_count_o), 32'd3);
        wait_cyc(b + 30); check("pending seq count", 32'(rst_count_o), 32'd4);

        // Request during RELEASE
        wait_cyc(b + 32);
        request(c);
        wait_cyc(c + 21); check("release out c21", 32'(rst_out_o), 32'hC);
        request(d);
`ifdef RST_SEQ_ABORT_EN
        check("abort ack cycle", 32'(d - c), 32'd22);
        check("abort out", 32'(rst_out_o), 32'hF);
        check("abort count", 32'(rst_count_o), 32'd4);
`else
        check("no abort ack cycle", 32'(d - c), 32'd31);
        check("no abort count", 32'(rst_count_o), 32'd5);
`endif
        wait_cyc(d + 16); check("after release req out +16", 32'(rst_out_o), 32'hE);
        wait_cyc(d + 30);
        check("after release req busy", 32'(rst_busy_o), 32'd0);
        check("after release req count", 32'(rst_count_o), ABORT ? 32'd5 : 32'd6);
        check("saturated count", 32'(sat_count), 32'd3);

        // Mid-sequence synchronous reset
        wait_cyc(d + 32);
        request(e);
        wait_cyc(e + 22);
        sync_rst = 1'b1;
        @(negedge clk);
        sync_rst = 1'b0;
        check("midrst cycle", 32'(cyc), 32'd0);
        check("midrst out", 32'(rst_out_o), 32'hF);
        check("midrst count", 32'(rst_count_o), 32'd0);
        check("midrst sat count", 32'(sat_count), 32'd0);
        wait_cyc(16); check("midrst out c16", 32'(rst_out_o), 32'hE);
        wait_cyc(29); check("midrst done c29", 32'(rst_done_o), 32'd1);
                      check("midrst count c29", 32'(rst_count_o), 32'd1);
        wait_cyc(30); check("midrst busy c30", 32'(rst_busy_o), 32'd0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
